md_stall_ctrl: RTL and testbench

//  Hazard/stall controller for the multiply-divide unit (mult/multu/div/divu,

---
 rtl/md_stall_ctrl.sv | 100 ++++++++++
 tb/tb_md_stall_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/md_stall_ctrl.sv
// md_stall_ctrl -- hazard/stall controller for the multiply-divide unit.
//
// Shadows the MD unit's busy window with its own FSM and down-counter. It
// raises stall_md (combinational) when a D-stage MD instruction would collide
// with an MD op that is starting in E or still in flight. It pulses md_done in
// the first cycle HI/LO hold the new result. It sets a sticky md_err if the
// shadow disagrees with md_busy, or if a start arrives while already busy.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   d_md_op       D-stage instruction is one of the 8 MD instructions
//   e_start       E-stage mult/multu/div/divu (MD unit start)
//   e_is_div      qualifies e_start: 1 = div/divu, 0 = mult/multu
//   md_busy       busy output of the MD unit
//   stall_md      freeze PC + F/D and bubble E
//   md_done       1-cycle pulse when the result lands in HI/LO
//   md_err        sticky desync / illegal-start flag
//   state         00 IDLE, 01 MUL, 10 DIV, 11 DONE (debug)
//   cycles_left   remaining busy cycles (debug)
module md_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CW          = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_md_op,
  input  logic          e_start,
  input  logic          e_is_div,
  input  logic          md_busy,
  output logic          stall_md,
  output logic          md_done,
  output logic          md_err,
  output logic [1:0]    state,
  output logic [CW-1:0] cycles_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } st_t;

  st_t          st_q;
  logic [CW-1:0] cl_q;
  logic          done_q;
  logic          err_q;
  logic          busy_shadow;

  assign busy_shadow = (st_q == S_MUL) || (st_q == S_DIV);

  // A start in E also stalls: the MD unit only raises md_busy the cycle after.
  assign stall_md    = d_md_op & (e_start | md_busy | busy_shadow);

  assign state       = st_q;
  assign cycles_left = cl_q;
  assign md_done     = done_q;
  assign md_err      = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= S_IDLE;
      cl_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        S_IDLE, S_DONE: begin
          // DONE accepts a back-to-back start exactly like IDLE.
          if (e_start && e_is_div) begin
            st_q <= S_DIV;
            cl_q <= CW'(DIV_CYCLES);
          end else if (e_start) begin
            st_q <= S_MUL;
            cl_q <= CW'(MULT_CYCLES);
          end else begin
            st_q <= S_IDLE;
            cl_q <= '0;
          end
        end
        default: begin
          // Busy: count down, never below zero. A start here should have been
          // stalled upstream, so it is dropped and flagged.
          if (cl_q <= CW'(1)) begin
            st_q   <= S_DONE;
            cl_q   <= '0;
            done_q <= 1'b1;
          end else begin
            cl_q <= cl_q - CW'(1);
          end
          if (e_start) err_q <= 1'b1;
        end
      endcase
      if (busy_shadow != md_busy) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md_stall_ctrl.sv
module tb_md_stall_ctrl;

  localparam logic [1:0] SI = 2'b00, SM = 2'b01, SD = 2'b10, SN = 2'b11;

  logic       clk = 1'b0;
  logic       reset, d_md_op, e_start, e_is_div, md_busy;
  logic       stall_md, md_done, md_err;
  logic [1:0] state;
  logic [3:0] cycles_left;

  md_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CW(4)) dut (
    .clk(clk), .reset(reset), .d_md_op(d_md_op), .e_start(e_start),
    .e_is_div(e_is_div), .md_busy(md_busy), .stall_md(stall_md),
    .md_done(md_done), .md_err(md_err), .state(state), .cycles_left(cycles_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [8:0] v;   // {stall, done, err, state[1:0], cycles_left[3:0]}
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // One clock cycle: drive inputs just after the edge, queue what the DUT
  // must show during this cycle (sampled by the monitor on the falling edge).
  task automatic cyc(input string tag, input logic rst, input logic d,
                     input logic es, input logic dv, input logic bz,
                     input logic chk, input logic x_stall, input logic x_done,
                     input logic x_err, input logic [1:0] x_st,
                     input logic [3:0] x_cl);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; d_md_op = d; e_start = es; e_is_div = dv; md_busy = bz;
    if (chk) begin
      e.tag = tag;
      e.v   = {x_stall, x_done, x_err, x_st, x_cl};
      q.push_back(e);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = {stall_md, md_done, md_err, state, cycles_left};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got stall/done/err/state/cl=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                   e.tag, act[8], act[7], act[6], act[5:4], act[3:0],
                   e.v[8], e.v[7], e.v[6], e.v[5:4], e.v[3:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; d_md_op = 1'b0; e_start = 1'b0; e_is_div = 1'b0; md_busy = 1'b0;

    // Reset and post-reset state
    cyc("rst",        1, 0,0,0,0, 0, 0,0,0,SI,0);
    cyc("reset_state",0, 0,0,0,0, 1, 0,0,0,SI,0);

    // Test 3: MD op in IDLE issues freely; start in E stalls same cycle
    cyc("idle_nostall",0, 1,0,0,0, 1, 0,0,0,SI,0);

    // Test 1: mult start (D op present -> stall), then busy window 5..1
    cyc("mul_start",  0, 1,1,0,0, 1, 1,0,0,SI,0);
    for (int i = 1; i <= 5; i++)
      cyc($sformatf("mul_c%0d", i), 0, 0,0,0,1, 1, 0,0,0,SM,4'(6-i));
    cyc("mul_done",   0, 0,0,0,0, 1, 0,1,0,SN,0);
    cyc("mul_idle",   0, 0,0,0,0, 1, 0,0,0,SI,0);

    // Test 2: div with mflo held in D: stall cycles 0-10, release at 11
    cyc("div_start",  0, 1,1,1,0, 1, 1,0,0,SI,0);
    for (int i = 1; i <= 10; i++)
      cyc($sformatf("div_c%0d", i), 0, 1,0,0,1, 1, 1,0,0,SD,4'(11-i));
    cyc("div_done",   0, 1,0,0,0, 1, 0,1,0,SN,0);
    cyc("div_idle",   0, 0,0,0,0, 1, 0,0,0,SI,0);

    // Test 5: mult, then div started in the DONE cycle
    cyc("b2b_mstart", 0, 0,1,0,0, 1, 0,0,0,SI,0);
    for (int i = 1; i <= 5; i++)
      cyc($sformatf("b2b_m%0d", i), 0, 0,0,0,1, 1, 0,0,0,SM,4'(6-i));
    cyc("b2b_done_start",0, 1,1,1,0, 1, 1,1,0,SN,0);
    for (int i = 1; i <= 10; i++)
      cyc($sformatf("b2b_d%0d", i), 0, 0,0,0,1, 1, 0,0,0,SD,4'(11-i));
    cyc("b2b_ddone",  0, 0,0,0,0, 1, 0,1,0,SN,0);
    cyc("b2b_idle",   0, 0,0,0,0, 1, 0,0,0,SI,0);

    // Test 4: reset at cycle 3 of a div aborts without md_done
    cyc("rdiv_start", 0, 0,1,1,0, 1, 0,0,0,SI,0);
    cyc("rdiv_c1",    0, 0,0,0,1, 1, 0,0,0,SD,10);
    cyc("rdiv_c2",    0, 0,0,0,1, 1, 0,0,0,SD,9);
    cyc("rdiv_c3_rst",1, 0,0,0,1, 1, 0,0,0,SD,8);
    cyc("rdiv_c4",    0, 0,0,0,0, 1, 0,0,0,SI,0);
    for (int i = 5; i <= 14; i++)
      cyc($sformatf("rdiv_nodone%0d", i), 0, 0,0,0,0, 1, 0,0,0,SI,0);

    // Test 6a: md_busy drops during MUL cycle 2 -> md_err sticky
    cyc("e1_start",   0, 0,1,0,0, 1, 0,0,0,SI,0);
    cyc("e1_c1",      0, 0,0,0,1, 1, 0,0,0,SM,5);
    cyc("e1_c2_drop", 0, 0,0,0,0, 1, 0,0,0,SM,4);
    cyc("e1_c3",      0, 0,0,0,1, 1, 0,0,1,SM,3);
    cyc("e1_c4",      0, 0,0,0,1, 1, 0,0,1,SM,2);
    cyc("e1_c5",      0, 0,0,0,1, 1, 0,0,1,SM,1);
    cyc("e1_done",    0, 0,0,0,0, 1, 0,1,1,SN,0);
    cyc("e1_held",    0, 1,0,0,0, 1, 0,0,1,SI,0);
    cyc("e1_rst",     1, 0,0,0,0, 1, 0,0,1,SI,0);
    cyc("e1_cleared", 0, 0,0,0,0, 1, 0,0,0,SI,0);

    // Test 6b: e_start during DIV is ignored and flags md_err
    cyc("e2_start",   0, 0,1,1,0, 1, 0,0,0,SI,0);
    cyc("e2_c1",      0, 0,0,0,1, 1, 0,0,0,SD,10);
    cyc("e2_c2_start",0, 1,1,0,1, 1, 1,0,0,SD,9);
    for (int i = 3; i <= 10; i++)
      cyc($sformatf("e2_c%0d", i), 0, 0,0,0,1, 1, 0,0,1,SD,4'(11-i));
    cyc("e2_done",    0, 0,0,0,0, 1, 0,1,1,SN,0);
    cyc("e2_held",    0, 0,0,0,0, 1, 0,0,1,SI,0);
    cyc("e2_rst",     1, 0,0,0,0, 1, 0,0,1,SI,0);
    cyc("e2_cleared", 0, 0,0,0,0, 1, 0,0,0,SI,0);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
